// File: rtl/store_aligner.sv
// Store aligner: narrows sb/sh/sw data, steers it onto word lanes and generates byte enables.
// Latency: mem_valid rises one cycle after acceptance; at most one store every two cycles.
// Backpressure: outputs are held until mem_ready; req_ready is low while a write is pending.
// Optional macro STORE_SPLIT_EN: misaligned stores become two beats instead of being dropped.
module store_aligner #(
    parameter int BIG_ENDIAN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_size,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        misalign,
    output logic        busy
);

`ifdef STORE_SPLIT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, SEND2 = 2'd2} state_t;
`else
    typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;
`endif

    state_t      state;
    state_t      state_nxt;
    logic        accept;
    logic        req_mis;
    logic [1:0]  off;
    logic [31:0] lanes;
    logic [3:0]  mask;

`ifdef STORE_SPLIT_EN
    // Two-word view of a store: the part that spills past the word boundary lands in beat 2.
    logic [63:0] wd_wide;
    logic [7:0]  mask_wide;
    logic [31:0] wd_b1;
    logic [31:0] wd_b2;
    logic [3:0]  be_b1;
    logic [3:0]  be_b2;
    logic [31:0] wd_hold;
    logic [3:0]  be_hold;
    logic        split_pend;
`else
    logic [3:0]  be_al;
`endif

    assign off       = req_addr[1:0];
    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign busy      = (state != IDLE);
    assign mem_valid = busy;

    // Replicate the store data across all lanes and pick the offset-0 enable mask.
    always_comb begin
        lanes   = req_data;
        mask    = 4'b1111;
        req_mis = 1'b0;
        case (req_size)
            2'b00: begin
                lanes = {4{req_data[7:0]}};
                mask  = (BIG_ENDIAN != 0) ? 4'b1000 : 4'b0001;
            end
            2'b01: begin
                lanes   = {2{req_data[15:0]}};
                mask    = (BIG_ENDIAN != 0) ? 4'b1100 : 4'b0011;
                req_mis = off[0];
            end
            default: begin
                req_mis = (off != 2'b00);
            end
        endcase
    end

`ifdef STORE_SPLIT_EN
    // Shift lanes and mask across a two-word window; the upper/lower half feeds each beat.
    always_comb begin
        if (BIG_ENDIAN != 0) begin
            wd_wide   = {lanes, 32'h0} >> {off, 3'b000};
            mask_wide = {mask, 4'b0000} >> off;
            wd_b1     = wd_wide[63:32];
            wd_b2     = wd_wide[31:0];
            be_b1     = mask_wide[7:4];
            be_b2     = mask_wide[3:0];
        end else begin
            wd_wide   = {32'h0, lanes} << {off, 3'b000};
            mask_wide = {4'b0000, mask} << off;
            wd_b1     = wd_wide[31:0];
            wd_b2     = wd_wide[63:32];
            be_b1     = mask_wide[3:0];
            be_b2     = mask_wide[7:4];
        end
    end
`else
    // Aligned stores never cross the word, so a plain 4-bit shift is enough.
    always_comb begin
        be_al = (BIG_ENDIAN != 0) ? (mask >> off) : (mask << off);
    end
`endif

    // Next-state logic: accept from IDLE, advance on each completed write beat.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
`ifdef STORE_SPLIT_EN
                if (accept) state_nxt = SEND;
`else
                if (accept && !req_mis) state_nxt = SEND;
`endif
            end
            SEND: begin
`ifdef STORE_SPLIT_EN
                if (mem_ready) state_nxt = split_pend ? SEND2 : IDLE;
`else
                if (mem_ready) state_nxt = IDLE;
`endif
            end
`ifdef STORE_SPLIT_EN
            SEND2: begin
                if (mem_ready) state_nxt = IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset drops any pending write.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Output registers: load on accept, swap in the second beat, pulse misalign on drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            mem_be     <= 4'h0;
            misalign   <= 1'b0;
`ifdef STORE_SPLIT_EN
            wd_hold    <= 32'h0;
            be_hold    <= 4'h0;
            split_pend <= 1'b0;
`endif
        end else begin
            misalign <= 1'b0;
            if (accept) begin
`ifdef STORE_SPLIT_EN
                mem_addr   <= {req_addr[31:2], 2'b00};
                split_pend <= req_mis;
                wd_hold    <= wd_b2;
                be_hold    <= be_b2;
                mem_wdata  <= req_mis ? wd_b1 : lanes;
                mem_be     <= be_b1;
`else
                if (req_mis) begin
                    misalign <= 1'b1;
                end else begin
                    mem_addr  <= {req_addr[31:2], 2'b00};
                    mem_wdata <= lanes;
                    mem_be    <= be_al;
                end
`endif
            end
`ifdef STORE_SPLIT_EN
            else if (state == SEND && state_nxt == SEND2) begin
                mem_addr   <= mem_addr + 32'd4;
                mem_wdata  <= wd_hold;
                mem_be     <= be_hold;
                split_pend <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_store_aligner.sv
// Bench for store_aligner: big- and little-endian instances share one stimulus stream.
// Expected writes come from a byte-addressed model and are checked by a negedge monitor.
// mem_ready is driven fixed-high, fixed-low or random to exercise backpressure.
module tb_store_aligner;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        mem_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;

    logic        be_req_ready, be_mem_valid, be_misalign, be_busy;
    logic [31:0] be_mem_addr, be_mem_wdata;
    logic [3:0]  be_mem_be;
    logic        le_req_ready, le_mem_valid, le_misalign, le_busy;
    logic [31:0] le_mem_addr, le_mem_wdata;
    logic [3:0]  le_mem_be;

    store_aligner #(.BIG_ENDIAN(1)) u_be (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(be_req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_valid(be_mem_valid), .mem_ready(mem_ready), .mem_addr(be_mem_addr),
        .mem_wdata(be_mem_wdata), .mem_be(be_mem_be), .misalign(be_misalign), .busy(be_busy)
    );

    store_aligner #(.BIG_ENDIAN(0)) u_le (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(le_req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
        .mem_valid(le_mem_valid), .mem_ready(mem_ready), .mem_addr(le_mem_addr),
        .mem_wdata(le_mem_wdata), .mem_be(le_mem_be), .misalign(le_misalign), .busy(le_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mis;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] bmask;
        logic [3:0]  be;
    } exp_t;

    exp_t q_be[$];
    exp_t q_le[$];
    exp_t log_be[$];
    exp_t log_le[$];

    int tests = 0;
    int fails = 0;
    int rdy_mode = 1;   // 0 random, 1 always ready, 2 stalled

    logic        hold[2];
    logic [31:0] h_addr[2];
    logic [31:0] h_wd[2];
    logic [3:0]  h_be[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s", name);
    endtask

    task automatic push_exp(input int big, input exp_t e);
        if (big != 0) q_be.push_back(e);
        else          q_le.push_back(e);
    endtask

    // Reference: place each stored byte at its byte address, then map address to lane.
    task automatic model_push(input int big, input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] sz, output logic mis);
        exp_t b[2];
        int   n;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        mis = (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'b00);
        for (int w = 0; w < 2; w++) begin
            b[w].mis   = 1'b0;
            b[w].addr  = {a[31:2], 2'b00} + 32'(4 * w);
            b[w].wdata = 32'h0;
            b[w].bmask = 32'h0;
            b[w].be    = 4'h0;
        end
        for (int j = 0; j < n; j++) begin
            int p, w, k, lane;
            logic [7:0] v;
            p    = int'(a[1:0]) + j;
            w    = p / 4;
            k    = p % 4;
            v    = (big != 0) ? d[8*(n-1-j) +: 8] : d[8*j +: 8];
            lane = (big != 0) ? 3 - k : k;
            b[w].wdata[8*lane +: 8] = v;
            b[w].bmask[8*lane +: 8] = 8'hFF;
            b[w].be[lane]           = 1'b1;
        end
        if (!mis) begin
            b[0].wdata = (sz == 2'd0) ? {4{d[7:0]}} : (sz == 2'd1) ? {2{d[15:0]}} : d;
            b[0].bmask = 32'hFFFF_FFFF;
            push_exp(big, b[0]);
        end else begin
`ifdef STORE_SPLIT_EN
            push_exp(big, b[0]);
            push_exp(big, b[1]);
`else
            b[0].mis = 1'b1;
            push_exp(big, b[0]);
`endif
        end
    endtask

    // Monitor one instance: writes and misalign pulses must match the head of its queue.
    task automatic mon(input int big, input logic mv, input logic mis, input logic [31:0] ma,
                       input logic [31:0] wd, input logic [3:0] be);
        exp_t  e;
        string tag;
        logic  empty;
        tag = (big != 0) ? "be" : "le";
        if (reset) begin
            hold[big] = 1'b0;
            return;
        end
        if (hold[big] && mv) begin
            check({tag, "_stall_addr"}, ma, h_addr[big]);
            check({tag, "_stall_wdata"}, wd, h_wd[big]);
            check({tag, "_stall_be"}, 32'(be), 32'(h_be[big]));
        end
        hold[big]   = mv && !mem_ready;
        h_addr[big] = ma;
        h_wd[big]   = wd;
        h_be[big]   = be;
        if (mv && mem_ready) begin
            empty = (big != 0) ? (q_be.size() == 0) : (q_le.size() == 0);
            if (empty) begin
                fail_now({tag, "_unexpected_write"});
            end else begin
                if (big != 0) e = q_be.pop_front();
                else          e = q_le.pop_front();
                if (e.mis) begin
                    fail_now({tag, "_write_instead_of_misalign"});
                end else begin
                    check({tag, "_addr"}, ma, e.addr);
                    check({tag, "_wdata"}, wd & e.bmask, e.wdata & e.bmask);
                    check({tag, "_be"}, 32'(be), 32'(e.be));
                end
                e.addr  = ma;
                e.wdata = wd;
                e.be    = be;
                if (big != 0) log_be.push_back(e);
                else          log_le.push_back(e);
            end
        end
        if (mis) begin
            empty = (big != 0) ? (q_be.size() == 0) : (q_le.size() == 0);
            if (empty) begin
                fail_now({tag, "_unexpected_misalign"});
            end else begin
                if (big != 0) e = q_be.pop_front();
                else          e = q_le.pop_front();
                check({tag, "_misalign_expected"}, 32'(e.mis), 32'd1);
            end
        end
    endtask

    initial begin
        hold[0] = 1'b0;
        hold[1] = 1'b0;
        forever begin
            @(negedge clk);
            mon(1, be_mem_valid, be_misalign, be_mem_addr, be_mem_wdata, be_mem_be);
            mon(0, le_mem_valid, le_misalign, le_mem_addr, le_mem_wdata, le_mem_be);
        end
    end

    initial begin
        mem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       mem_ready = ($urandom_range(0, 3) != 0);
                1:       mem_ready = 1'b1;
                default: mem_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        logic mis_b, mis_l;
        req_addr  = a;
        req_data  = d;
        req_size  = sz;
        req_valid = 1'b1;
        for (int k = 0; k < 100 && !be_req_ready; k++) begin
            @(posedge clk);
            #1;
        end
        if (!be_req_ready) begin
            fail_now("req_ready_timeout");
            req_valid = 1'b0;
            return;
        end
        model_push(1, a, d, sz, mis_b);
        model_push(0, a, d, sz, mis_l);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_data  = $urandom;
`ifdef STORE_SPLIT_EN
        check("accept_latency", 32'(be_mem_valid), 32'd1);
`else
        check("accept_latency", 32'(be_mem_valid), 32'(!mis_b));
`endif
    endtask

    task automatic wait_done();
        for (int k = 0; k < 300; k++) begin
            if (q_be.size() == 0 && q_le.size() == 0 && !be_busy && !le_busy) return;
            @(posedge clk);
            #1;
        end
        fail_now("completion_timeout");
    endtask

    task automatic clear_logs();
        log_be.delete();
        log_le.delete();
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        req_data  = 32'h0;
        req_size  = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_valid", 32'(be_mem_valid), 32'd0);
        check("rst_busy", 32'(be_busy), 32'd0);
        check("rst_misalign", 32'(be_misalign), 32'd0);
        check("rst_req_ready", 32'(be_req_ready), 32'd0);
        check("rst_mem_addr", be_mem_addr, 32'h0);
        check("rst_mem_wdata", be_mem_wdata, 32'h0);
        check("rst_mem_be", 32'(be_mem_be), 32'd0);
        check("rst_le_mem_valid", 32'(le_mem_valid), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_req_ready", 32'(be_req_ready), 32'd1);

        // sb to offset 2
        rdy_mode = 1;
        clear_logs();
        do_store(32'h0000_1002, 32'h0000_00AB, 2'b00);
        wait_done();
        check("sb_be_count", 32'(log_be.size()), 32'd1);
        check("sb_le_count", 32'(log_le.size()), 32'd1);
        if (log_be.size() > 0 && log_le.size() > 0) begin
            check("sb_be_addr", log_be[0].addr, 32'h0000_1000);
            check("sb_be_wdata", log_be[0].wdata, 32'hABAB_ABAB);
            check("sb_be_mask", 32'(log_be[0].be), 32'h2);
            check("sb_le_mask", 32'(log_le[0].be), 32'h4);
        end

        // sh with memory stalled for three cycles
        rdy_mode = 2;
        @(posedge clk);
        #1;
        clear_logs();
        do_store(32'h0000_2002, 32'h0000_1234, 2'b01);
        for (int i = 0; i < 3; i++) begin
            check("sh_stall_valid", 32'(le_mem_valid), 32'd1);
            check("sh_stall_wdata", le_mem_wdata, 32'h1234_1234);
            check("sh_stall_be", 32'(le_mem_be), 32'hC);
            check("sh_stall_req_ready", 32'(le_req_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        rdy_mode = 1;
        wait_done();
        check("sh_le_count", 32'(log_le.size()), 32'd1);
        if (log_le.size() > 0) begin
            check("sh_le_addr", log_le[0].addr, 32'h0000_2000);
            check("sh_le_wdata", log_le[0].wdata, 32'h1234_1234);
        end

`ifdef STORE_SPLIT_EN
        clear_logs();
        do_store(32'h0000_3001, 32'h1122_3344, 2'b10);
        wait_done();
        check("split_sw_count", 32'(log_be.size()), 32'd2);
        if (log_be.size() == 2) begin
            check("split_sw_b1_addr", log_be[0].addr, 32'h0000_3000);
            check("split_sw_b1_wdata", log_be[0].wdata, 32'h0011_2233);
            check("split_sw_b1_be", 32'(log_be[0].be), 32'h7);
            check("split_sw_b2_addr", log_be[1].addr, 32'h0000_3004);
            check("split_sw_b2_wdata", log_be[1].wdata, 32'h4400_0000);
            check("split_sw_b2_be", 32'(log_be[1].be), 32'h8);
        end
        clear_logs();
        do_store(32'hFFFF_FFFF, 32'h0000_BEEF, 2'b01);
        wait_done();
        check("split_wrap_count", 32'(log_be.size()), 32'd2);
        if (log_be.size() == 2) begin
            check("split_wrap_b1_addr", log_be[0].addr, 32'hFFFF_FFFC);
            check("split_wrap_b1_be", 32'(log_be[0].be), 32'h1);
            check("split_wrap_b2_addr", log_be[1].addr, 32'h0000_0000);
            check("split_wrap_b2_be", 32'(log_be[1].be), 32'h8);
        end
`else
        clear_logs();
        do_store(32'h0000_3001, 32'h1122_3344, 2'b10);
        check("mis_pulse", 32'(be_misalign), 32'd1);
        check("mis_no_valid", 32'(be_mem_valid), 32'd0);
        check("mis_not_busy", 32'(be_busy), 32'd0);
        check("mis_req_ready", 32'(be_req_ready), 32'd1);
        @(posedge clk);
        #1;
        check("mis_pulse_end", 32'(be_misalign), 32'd0);
        wait_done();
        check("mis_no_write", 32'(log_be.size()), 32'd0);
`endif

        // reset while a write is stalled
        rdy_mode = 2;
        @(posedge clk);
        #1;
        clear_logs();
        do_store(32'h0000_4000, 32'hDEAD_BEEF, 2'b10);
        @(posedge clk);
        #1;
        check("rstmid_pending", 32'(be_mem_valid), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid_valid", 32'(be_mem_valid), 32'd0);
        check("rstmid_busy", 32'(be_busy), 32'd0);
        check("rstmid_misalign", 32'(be_misalign), 32'd0);
        check("rstmid_req_ready", 32'(be_req_ready), 32'd0);
        check("rstmid_le_valid", 32'(le_mem_valid), 32'd0);
        q_be.delete();
        q_le.delete();
        reset    = 1'b0;
        rdy_mode = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rstmid_no_write", 32'(log_be.size() + log_le.size()), 32'd0);

        // randomized traffic with random backpressure
        rdy_mode = 0;
        for (int t = 0; t < 300; t++) begin
            logic [31:0] a, d;
            logic [1:0]  sz;
            a  = $urandom;
            d  = $urandom;
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            do_store(a, d, sz);
        end
        rdy_mode = 1;
        wait_done();
        check("final_be_queue_empty", 32'(q_be.size()), 32'd0);
        check("final_le_queue_empty", 32'(q_le.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
